// File: rtl/alu_steuerung_if.sv
// Bus bundle between the request source, the ALU sequencer and the ALU itself.
// The sequencer uses the slave view; the bench or the surrounding core uses the master view.
interface alu_steuerung_if;
  logic        AuftragGueltig;
  logic        AuftragBereit;
  logic [31:0] AuftragDaten1;
  logic [31:0] AuftragDaten2;
  logic [5:0]  AuftragCode;
  logic [4:0]  AuftragZiel;
  logic [31:0] Daten1;
  logic [31:0] Daten2;
  logic [5:0]  Funktionscode;
  logic        StartSignal;
  logic        Schreibsignal;
  logic [31:0] Ergebnis;
  logic        Fertig;
  logic        RueckGueltig;
  logic        RueckBereit;
  logic [31:0] RueckDaten;
  logic [4:0]  RueckZiel;
  logic        Fehler;

  modport slave (
    input  AuftragGueltig, AuftragDaten1, AuftragDaten2, AuftragCode, AuftragZiel,
    input  Ergebnis, Fertig, RueckBereit,
    output AuftragBereit, Daten1, Daten2, Funktionscode, StartSignal, Schreibsignal,
    output RueckGueltig, RueckDaten, RueckZiel, Fehler
  );

  modport master (
    output AuftragGueltig, AuftragDaten1, AuftragDaten2, AuftragCode, AuftragZiel,
    output Ergebnis, Fertig, RueckBereit,
    input  AuftragBereit, Daten1, Daten2, Funktionscode, StartSignal, Schreibsignal,
    input  RueckGueltig, RueckDaten, RueckZiel, Fehler
  );
endinterface

// File: rtl/alu_steuerung.sv
// ALU sequencer: accepts one operation, strobes the ALU, waits for multi-cycle ops with a
// timeout, and hands the result back over a valid/ready writeback port.
module alu_steuerung #(
  parameter int WARTE_MAX = 63
) (
  input  logic           Clock,
  input  logic           Reset,
  alu_steuerung_if.slave bus
);

  typedef enum logic [2:0] {LEERLAUF, START, WARTEN, SCHREIBEN, ERFASSEN, ABGABE} zustand_t;
  typedef enum logic [1:0] {ILLEGAL, EINZEL, MEHRFACH} klasse_t;

  localparam logic [7:0] ZAEHLER_LETZT = 8'(WARTE_MAX - 1);

  zustand_t   zustand;
  logic [7:0] zaehler;

  // sqrt/div/mod need Fertig; everything outside the listed ranges (incl. bit5 set) is illegal
  function automatic klasse_t klasse(input logic [5:0] code);
    if (code inside {6'd3, 6'd4, 6'd5})
      return MEHRFACH;
    else if (code inside {[6'd0:6'd2], [6'd6:6'd9], [6'd16:6'd21], [6'd24:6'd28]})
      return EINZEL;
    else
      return ILLEGAL;
  endfunction

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      zustand           <= LEERLAUF;
      zaehler           <= '0;
      bus.AuftragBereit <= 1'b0;
      bus.Daten1        <= '0;
      bus.Daten2        <= '0;
      bus.Funktionscode <= '0;
      bus.StartSignal   <= 1'b0;
      bus.Schreibsignal <= 1'b0;
      bus.RueckGueltig  <= 1'b0;
      bus.RueckDaten    <= '0;
      bus.RueckZiel     <= '0;
      bus.Fehler        <= 1'b0;
    end else begin
      bus.StartSignal   <= 1'b0;
      bus.Schreibsignal <= 1'b0;
      bus.Fehler        <= 1'b0;
      case (zustand)
        LEERLAUF: begin
          bus.AuftragBereit <= 1'b1;
          if (bus.AuftragGueltig && bus.AuftragBereit) begin
            bus.AuftragBereit <= 1'b0;
            bus.Daten1        <= bus.AuftragDaten1;
            bus.Daten2        <= bus.AuftragDaten2;
            bus.Funktionscode <= bus.AuftragCode;
            bus.RueckZiel     <= bus.AuftragZiel;
            if (klasse(bus.AuftragCode) == ILLEGAL) begin
              bus.RueckDaten   <= '0;
              bus.RueckGueltig <= 1'b1;
              bus.Fehler       <= 1'b1;
              zustand          <= ABGABE;
            end else begin
              bus.StartSignal <= 1'b1;
              zustand         <= START;
            end
          end
        end
        START: begin
          if (klasse(bus.Funktionscode) == MEHRFACH) begin
            zaehler <= '0;
            zustand <= WARTEN;
          end else begin
            bus.Schreibsignal <= 1'b1;
            zustand           <= SCHREIBEN;
          end
        end
        WARTEN: begin
          // Fertig wins over a timeout landing on the same cycle
          if (bus.Fertig) begin
            bus.Schreibsignal <= 1'b1;
            zustand           <= SCHREIBEN;
          end else if (zaehler == ZAEHLER_LETZT) begin
            bus.RueckDaten   <= 32'hFFFF_FFFF;
            bus.RueckGueltig <= 1'b1;
            bus.Fehler       <= 1'b1;
            zustand          <= ABGABE;
          end else begin
            zaehler <= zaehler + 8'd1;
          end
        end
        SCHREIBEN: zustand <= ERFASSEN;
        ERFASSEN: begin
          bus.RueckDaten   <= bus.Ergebnis;
          bus.RueckGueltig <= 1'b1;
          zustand          <= ABGABE;
        end
        ABGABE: begin
          if (bus.RueckBereit) begin
            bus.RueckGueltig  <= 1'b0;
            bus.AuftragBereit <= 1'b1;
            zustand           <= LEERLAUF;
          end
        end
        default: zustand <= LEERLAUF;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_steuerung.sv
// Randomized bench for alu_steuerung: two instances (default timeout and WARTE_MAX=8) share
// stimulus; a per-transaction event model predicts every strobe cycle and the writeback value.
module tb_alu_steuerung;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  alu_steuerung_if ifA ();
  alu_steuerung_if ifB ();

  alu_steuerung dutA (.Clock(Clock), .Reset(Reset), .bus(ifA));
  alu_steuerung #(.WARTE_MAX(8)) dutB (.Clock(Clock), .Reset(Reset), .bus(ifB));

  logic        sel = 1'b0;
  logic        gueltig = 1'b0;
  logic [31:0] d1 = '0, d2 = '0, erg = '0;
  logic [5:0]  code = '0;
  logic [4:0]  ziel = '0;
  logic        fertig = 1'b0, rBereit = 1'b0;

  assign ifA.AuftragGueltig = gueltig & ~sel;
  assign ifB.AuftragGueltig = gueltig & sel;
  assign ifA.AuftragDaten1 = d1;   assign ifB.AuftragDaten1 = d1;
  assign ifA.AuftragDaten2 = d2;   assign ifB.AuftragDaten2 = d2;
  assign ifA.AuftragCode   = code; assign ifB.AuftragCode   = code;
  assign ifA.AuftragZiel   = ziel; assign ifB.AuftragZiel   = ziel;
  assign ifA.Ergebnis      = erg;  assign ifB.Ergebnis      = erg;
  assign ifA.Fertig        = fertig;  assign ifB.Fertig        = fertig;
  assign ifA.RueckBereit   = rBereit; assign ifB.RueckBereit   = rBereit;

  logic        oBereit, oStart, oSchreib, oRg, oFehler;
  logic [31:0] oD1, oD2, oRd;
  logic [5:0]  oCode;
  logic [4:0]  oZiel;
  assign oBereit  = sel ? ifB.AuftragBereit : ifA.AuftragBereit;
  assign oStart   = sel ? ifB.StartSignal   : ifA.StartSignal;
  assign oSchreib = sel ? ifB.Schreibsignal : ifA.Schreibsignal;
  assign oRg      = sel ? ifB.RueckGueltig  : ifA.RueckGueltig;
  assign oFehler  = sel ? ifB.Fehler        : ifA.Fehler;
  assign oD1      = sel ? ifB.Daten1        : ifA.Daten1;
  assign oD2      = sel ? ifB.Daten2        : ifA.Daten2;
  assign oRd      = sel ? ifB.RueckDaten    : ifA.RueckDaten;
  assign oCode    = sel ? ifB.Funktionscode : ifA.Funktionscode;
  assign oZiel    = sel ? ifB.RueckZiel     : ifA.RueckZiel;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h @%0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    bit          s;      // 1: WARTE_MAX=8 instance
    logic [31:0] a, b, e;
    logic [5:0]  c;
    logic [4:0]  z;
    int          k;      // WARTEN cycle index in which Fertig rises (>= WARTE_MAX: never)
    int          bp;     // cycles RueckBereit stays low in ABGABE
    bit          pend;   // next request already presented during writeback
  } txn_t;

  txn_t q[$];

  function automatic bit isMulti(input logic [5:0] c);
    return c inside {6'd3, 6'd4, 6'd5};
  endfunction
  function automatic bit isLegal(input logic [5:0] c);
    return isMulti(c) || (c inside {[6'd0:6'd2], [6'd6:6'd9], [6'd16:6'd21], [6'd24:6'd28]});
  endfunction

  // Cycle numbers are counted from the acceptance edge: cycle 1 is the one right after it.
  task automatic runTxn(input txn_t t, input txn_t n, input bit hasNext);
    int  wm, abg, schr, fin, wEnd, w;
    bit  legal, multi, err, pendUse, inWait;
    logic [31:0] rd;
    wm    = t.s ? 8 : 63;
    legal = isLegal(t.c);
    multi = isMulti(t.c);
    err   = 0;
    schr  = 0;
    wEnd  = 0;
    rd    = t.e;
    if (!legal) begin
      abg = 1; err = 1; rd = 32'h0;
    end else if (!multi) begin
      schr = 2; abg = 4;
    end else if (t.k < wm) begin
      schr = 3 + t.k; abg = 5 + t.k; wEnd = 1 + t.k;
    end else begin
      abg = 2 + wm; err = 1; rd = 32'hFFFF_FFFF; wEnd = 1 + wm;
    end
    fin     = abg + t.bp + 1;
    pendUse = hasNext && t.pend && (n.s == t.s);

    sel = t.s; d1 = t.a; d2 = t.b; code = t.c; ziel = t.z; gueltig = 1'b1;
    w = 0;
    while (oBereit !== 1'b1 && w < 30) begin
      @(posedge Clock); @(negedge Clock); w++;
    end
    chk("acceptWait", 32'(w < 30), 32'd1);
    if (w >= 30) return;
    @(posedge Clock);

    for (int c = 1; c <= fin; c++) begin
      @(negedge Clock);
      chk("start",   32'(oStart),   32'(c == 1 && legal));
      chk("schreib", 32'(oSchreib), 32'(schr != 0 && c == schr));
      chk("fehler",  32'(oFehler),  32'(err && c == abg));
      chk("rueckG",  32'(oRg),      32'(c >= abg && c < fin));
      chk("bereit",  32'(oBereit),  32'(c == fin));
      chk("daten1",  oD1, t.a);
      chk("daten2",  oD2, t.b);
      chk("fcode",   32'(oCode), 32'(t.c));
      if (c >= abg && c < fin) begin
        chk("rueckD", oRd, rd);
        chk("rueckZ", 32'(oZiel), 32'(t.z));
      end
      inWait  = multi && c >= 2 && c <= wEnd;
      fertig  = (multi && t.k < wm && c == 2 + t.k) ? 1'b1 : (inWait ? 1'b0 : 1'($urandom));
      erg     = (schr != 0 && c == schr + 1) ? t.e : $urandom;
      rBereit = (c >= abg + t.bp) ? 1'b1 : ((c >= abg) ? 1'b0 : 1'($urandom));
      if (pendUse && c >= abg) begin
        d1 = n.a; d2 = n.b; code = n.c; ziel = n.z; gueltig = 1'b1;
      end else if (c == fin) begin
        gueltig = 1'b0;
      end else begin
        gueltig = 1'($urandom); d1 = $urandom; d2 = $urandom;
        code = 6'($urandom); ziel = 5'($urandom);
      end
    end
  endtask

  task automatic runQueue();
    for (int i = 0; i < q.size(); i++)
      runTxn(q[i], q[(i + 1 < q.size()) ? i + 1 : i], i + 1 < q.size());
    q.delete();
  endtask

  function automatic txn_t mk(bit s, logic [31:0] a, logic [31:0] b, logic [5:0] c,
                              logic [4:0] z, logic [31:0] e, int k, int bp, bit pend);
    txn_t t;
    t.s = s; t.a = a; t.b = b; t.c = c; t.z = z; t.e = e; t.k = k; t.bp = bp; t.pend = pend;
    return t;
  endfunction

  task automatic chkAllZero(input string tag);
    chk({tag, "_bereit"}, 32'(oBereit), 32'd0);
    chk({tag, "_start"},  32'(oStart),  32'd0);
    chk({tag, "_schr"},   32'(oSchreib), 32'd0);
    chk({tag, "_rg"},     32'(oRg),     32'd0);
    chk({tag, "_fehler"}, 32'(oFehler), 32'd0);
    chk({tag, "_d1"},     oD1, 32'd0);
    chk({tag, "_d2"},     oD2, 32'd0);
    chk({tag, "_rd"},     oRd, 32'd0);
    chk({tag, "_code"},   32'(oCode), 32'd0);
    chk({tag, "_ziel"},   32'(oZiel), 32'd0);
  endtask

  initial begin
    int r;
    txn_t t;
    #2;
    chkAllZero("rstA");
    sel = 1'b1; #1; chkAllZero("rstB"); sel = 1'b0;
    @(negedge Clock); Reset = 1'b0;
    @(posedge Clock); @(negedge Clock);
    chk("bereitAfterRst", 32'(oBereit), 32'd1);

    // directed: add, div, timeout on the short instance, illegal, backpressure with pending request
    q.push_back(mk(0, 32'd5, 32'd7, 6'b000000, 5'd3, 32'd12, 0, 0, 0));
    q.push_back(mk(0, 32'd100, 32'd3, 6'b000100, 5'd9, 32'h2A, 10, 1, 0));
    q.push_back(mk(1, 32'd49, 32'd0, 6'b000011, 5'd4, 32'h1234, 1000, 0, 0));
    q.push_back(mk(0, 32'd1, 32'd2, 6'b100000, 5'd7, 32'h55, 0, 2, 0));
    q.push_back(mk(0, 32'hA, 32'hB, 6'b010001, 5'd12, 32'hCAFE, 0, 5, 1));
    q.push_back(mk(0, 32'h20, 32'h8, 6'b000001, 5'd13, 32'h18, 0, 0, 0));
    q.push_back(mk(1, 32'd9, 32'd3, 6'b000101, 5'd1, 32'd0, 7, 1, 0));
    runQueue();

    // reset in WARTEN: everything clears at once and the operation leaves no trace
    sel = 1'b0; d1 = 32'h77; d2 = 32'h11; code = 6'b000100; ziel = 5'd5; gueltig = 1'b1;
    @(posedge Clock);
    gueltig = 1'b0; fertig = 1'b0; rBereit = 1'b1;
    repeat (5) @(negedge Clock);
    #1 Reset = 1'b1;
    #1 chkAllZero("midRst");
    @(posedge Clock); @(negedge Clock);
    Reset = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clock);
      fertig = 1'($urandom);
      chk("postRst_rg", 32'(oRg), 32'd0);
      chk("postRst_fehler", 32'(oFehler), 32'd0);
      chk("postRst_bereit", 32'(oBereit), 32'd1);
    end

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 3);
      t.s = 1'($urandom);
      t.a = $urandom; t.b = $urandom; t.e = $urandom; t.z = 5'($urandom);
      t.c = (r == 0) ? 6'($urandom) : (r == 1) ? 6'(3 + $urandom_range(0, 2)) : 6'($urandom_range(0, 31));
      t.k = t.s ? $urandom_range(0, 10) : (($urandom_range(0, 9) == 0) ? 200 : $urandom_range(0, 14));
      t.bp = $urandom_range(0, 4);
      t.pend = 1'($urandom);
      q.push_back(t);
    end
    runQueue();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_steuerung.md
ALU_STEUERUNG -- requirements
Module: alu_steuerung

Interface
REQ-001 SHALL have parameter WARTE_MAX, default 63: max cycles in WARTEN before timeout (1..255).
REQ-002 SHALL have port Clock  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports AuftragGueltig in 1 and AuftragBereit out 1: request valid/ready handshake.
REQ-005 SHALL have ports AuftragDaten1 in 32, AuftragDaten2 in 32, AuftragCode in 6, AuftragZiel in 5: operands, function code, destination register.
REQ-006 SHALL have ports Daten1 out 32, Daten2 out 32, Funktionscode out 6: registered operands and code driven to the ALU.
REQ-007 SHALL have ports StartSignal out 1 and Schreibsignal out 1: ALU start and result-write strobes.
REQ-008 SHALL have ports Ergebnis in 32 (ALU result) and Fertig in 1 (multi-cycle op done).
REQ-009 SHALL have ports RueckGueltig out 1, RueckBereit in 1, RueckDaten out 32, RueckZiel out 5: writeback valid/ready handshake.
REQ-010 SHALL have port Fehler out 1: one-cycle pulse on illegal code or timeout.

Function
REQ-011 SHALL implement states LEERLAUF, START, WARTEN, SCHREIBEN, ERFASSEN, ABGABE; all outputs registered.
REQ-012 SHALL drive AuftragBereit=1 only in LEERLAUF.
REQ-013 SHALL, on AuftragGueltig&AuftragBereit, latch AuftragDaten1/2, AuftragCode, AuftragZiel into Daten1/2, Funktionscode, RueckZiel.
REQ-014 SHALL classify codes: multi-cycle = 000011 (sqrt), 000100 (div), 000101 (mod); single-cycle = 000000-000010, 000110-001001, 010000-010101, 011000-011100; all others, including any with bit5=1, illegal.
REQ-015 SHALL, for an illegal code, go LEERLAUF->ABGABE with RueckDaten=0, pulse Fehler in the ABGABE entry cycle, and never assert StartSignal or Schreibsignal.
REQ-016 SHALL, for a legal code, go LEERLAUF->START and hold StartSignal=1 exactly one cycle in START.
REQ-017 SHALL go START->SCHREIBEN for single-cycle codes, and START->WARTEN with wait counter cleared to 0 for multi-cycle codes.
REQ-018 SHALL ignore Fertig in every state except WARTEN.
REQ-019 SHALL, in WARTEN, increment the counter each cycle; on Fertig=1 go to SCHREIBEN (Fertig takes priority over timeout in the same cycle).
REQ-020 SHALL, in WARTEN with counter==WARTE_MAX-1 and Fertig=0, go to ABGABE with RueckDaten=32'hFFFFFFFF and pulse Fehler; no Schreibsignal.
REQ-021 SHALL hold Schreibsignal=1 exactly one cycle in SCHREIBEN, then go to ERFASSEN.
REQ-022 SHALL, at the end of ERFASSEN, capture Ergebnis into RueckDaten and go to ABGABE.
REQ-023 SHALL assert RueckGueltig throughout ABGABE, holding RueckDaten/RueckZiel stable until RueckGueltig&RueckBereit, then return to LEERLAUF.
REQ-024 SHALL hold Daten1/2 and Funktionscode stable from acceptance until return to LEERLAUF.
REQ-025 SHALL give single-cycle latency: accept at edge N; StartSignal in cycle N+1; Schreibsignal in N+2; RueckGueltig from cycle N+4.
REQ-026 SHALL give multi-cycle latency: Schreibsignal in the cycle after Fertig is sampled in WARTEN; RueckGueltig two cycles later.
REQ-027 SHALL accept no new request while busy; back-to-back requests are separated by at least one LEERLAUF cycle.

Reset
REQ-028 SHALL, while Reset=1, force state LEERLAUF, counter 0, and all outputs to 0 (including AuftragBereit), asynchronously.
REQ-029 SHALL, on Reset mid-operation, abandon the operation: no RueckGueltig or Fehler for it afterwards.
REQ-030 SHALL drive AuftragBereit=1 in the first cycle after Reset deasserts.

Verification
REQ-031 SHALL test add: Daten 5, 7, code 000000, Ziel 3, model Ergebnis=12 -> Start at N+1, Schreib at N+2, RueckGueltig at N+4 with 12, RueckZiel 3.
REQ-032 SHALL test div: code 000100, Fertig after 10 WARTEN cycles, Ergebnis=0x2A -> one Schreibsignal the cycle after Fertig, RueckDaten 0x2A.
REQ-033 SHALL test timeout: WARTE_MAX=8, code 000011, Fertig never -> RueckDaten 0xFFFFFFFF, Fehler one cycle, no Schreibsignal.
REQ-034 SHALL test illegal code 100000 -> no Start/Schreib, RueckDaten 0, Fehler pulse.
REQ-035 SHALL test backpressure: RueckBereit low 5 cycles with new request pending -> RueckDaten stable, AuftragBereit 0, request accepted only after writeback handshake.
REQ-036 SHALL test Reset pulse in WARTEN -> all outputs 0 immediately, LEERLAUF, no later RueckGueltig.
